// File: rtl/maze_pkg.sv
// maze_pkg: cell-state codes, command codes, packet layout and receiver FSM states shared by the maze update path
package maze_pkg;

    typedef enum logic [1:0] {
        CELL_UNSEEN   = 2'b00,
        CELL_VISITED  = 2'b01,
        CELL_ROBOT    = 2'b10,
        CELL_TREASURE = 2'b11
    } cell_e;

    typedef enum logic [1:0] {
        CMD_CLEAR    = 2'b00,
        CMD_VISIT    = 2'b01,
        CMD_ROBOT    = 2'b10,
        CMD_TREASURE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_WRITE
    } state_e;

    localparam int PKT_BITS = 8;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        cmd_e       cmd;
    } pkt_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser with single-cycle rise/fall pulses on the synchronised level
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/maze_update_rx.sv
// maze_update_rx: serial cell-update receiver maintaining the maze cell array with a registered read port
module maze_update_rx
    import maze_pkg::*;
#(
    parameter int GRID_W      = 4,
    parameter int GRID_H      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       SER_SCLK,
    input  logic       SER_SDATA,
    input  logic       SER_CS_N,
    input  logic [2:0] RD_X,
    input  logic [2:0] RD_Y,
    output logic [1:0] RD_STATE,
    output logic       PKT_VALID,
    output logic       PKT_ERR,
    output logic [2:0] ROBOT_X,
    output logic [2:0] ROBOT_Y
);
    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IW      = $clog2(2 * N_CELLS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sdata, sdata_rise, sdata_fall;
    logic unused_sync;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(CLOCK), .rst(RESET), .d(SER_SCLK), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    // CS_N idles high, so its synchroniser resets high to avoid a phantom frame start.
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(CLOCK), .rst(RESET), .d(SER_CS_N), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata (
        .clk(CLOCK), .rst(RESET), .d(SER_SDATA), .level(sdata), .rise(sdata_rise), .fall(sdata_fall)
    );

    assign unused_sync = ^{sclk_level, sclk_fall, cs_level, sdata_rise, sdata_fall};

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [PKT_BITS-1:0]    shift_q, shift_d;
    logic [2*N_CELLS-1:0]   cells_q, cells_d;
    logic [1:0]             rd_state_q, rd_state_d;
    logic                   valid_q, valid_d, err_q, err_d;
    logic [2:0]             robot_x_q, robot_x_d, robot_y_q, robot_y_d;

    pkt_t        pkt;
    logic        in_range, rd_in_range, robot_move;
    logic [IW-1:0] wr_base, old_base, rd_base;

    assign pkt         = pkt_t'(shift_q);
    assign in_range    = ({1'b0, pkt.x} < 4'(GRID_W)) && ({1'b0, pkt.y} < 4'(GRID_H));
    assign rd_in_range = ({1'b0, RD_X} < 4'(GRID_W)) && ({1'b0, RD_Y} < 4'(GRID_H));
    assign robot_move  = (pkt.cmd == CMD_ROBOT) && ((pkt.x != robot_x_q) || (pkt.y != robot_y_q));
    assign wr_base     = IW'(2 * (int'(pkt.y) * GRID_W + int'(pkt.x)));
    assign old_base    = IW'(2 * (int'(robot_y_q) * GRID_W + int'(robot_x_q)));
    assign rd_base     = IW'(2 * (int'(RD_Y) * GRID_W + int'(RD_X)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        cells_d    = cells_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        robot_x_d  = robot_x_q;
        robot_y_d  = robot_y_q;
        rd_state_d = rd_in_range ? cells_q[rd_base +: 2] : 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[PKT_BITS-2:0], sdata};
                    cnt_d   = (cnt_q == 4'd9) ? cnt_q : cnt_q + 4'd1;
                end
                if (cs_rise) begin
                    state_d = (cnt_q == 4'd8) ? ST_CHECK : ST_IDLE;
                    err_d   = (cnt_q != 4'd8);
                end
            end
            ST_CHECK: begin
                state_d = in_range ? ST_WRITE : ST_IDLE;
                valid_d = in_range;
                err_d   = !in_range;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (robot_move) cells_d[old_base +: 2] = CELL_VISITED;
                cells_d[wr_base +: 2] = cell_e'(pkt.cmd);
                if (pkt.cmd == CMD_ROBOT) begin
                    robot_x_d = pkt.x;
                    robot_y_d = pkt.y;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            cells_q    <= '0;
            rd_state_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            robot_x_q  <= '0;
            robot_y_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            cells_q    <= cells_d;
            rd_state_q <= rd_state_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            robot_x_q  <= robot_x_d;
            robot_y_q  <= robot_y_d;
        end
    end

    assign RD_STATE  = rd_state_q;
    assign PKT_VALID = valid_q;
    assign PKT_ERR   = err_q;
    assign ROBOT_X   = robot_x_q;
    assign ROBOT_Y   = robot_y_q;

endmodule

// File: tb/tb_maze_update_rx.sv
// tb_maze_update_rx: directed serial frames checked every cycle against a cell-array model of the maze receiver
module tb_maze_update_rx;
    localparam int GW = 4;
    localparam int GH = 5;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sclk = 1'b0, sdata = 1'b0, cs_n = 1'b1;
    logic [2:0] rd_x = '0, rd_y = '0;
    logic [1:0] rd_state;
    logic       pkt_valid, pkt_err;
    logic [2:0] robot_x, robot_y;

    int checks = 0, errors = 0;
    int model [GW*GH];
    int mrx = 0, mry = 0, exp_rd = 0, n_valid = 0, n_err = 0;
    logic [7:0] pend [$];

    maze_update_rx #(.GRID_W(GW), .GRID_H(GH), .SYNC_STAGES(2)) dut (
        .CLOCK(clk), .RESET(rst), .SER_SCLK(sclk), .SER_SDATA(sdata), .SER_CS_N(cs_n),
        .RD_X(rd_x), .RD_Y(rd_y), .RD_STATE(rd_state), .PKT_VALID(pkt_valid), .PKT_ERR(pkt_err),
        .ROBOT_X(robot_x), .ROBOT_Y(robot_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int lookup(input int x, input int y);
        return (x < GW && y < GH) ? model[y*GW + x] : 0;
    endfunction

    function automatic void apply(input logic [7:0] p);
        int x = int'(p[7:5]);
        int y = int'(p[4:2]);
        int c = int'(p[1:0]);
        if (c == 2 && (x != mrx || y != mry)) model[mry*GW + mrx] = 1;
        model[y*GW + x] = c;
        if (c == 2) begin
            mrx = x;
            mry = y;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_rd", int'(rd_state), 0);
            chk("reset_pulses", int'({pkt_valid, pkt_err}), 0);
            foreach (model[i]) model[i] = 0;
            mrx = 0;
            mry = 0;
            exp_rd = 0;
            pend.delete();
        end else begin
            chk("rd_state", int'(rd_state), exp_rd);
            chk("robot_x", int'(robot_x), mrx);
            chk("robot_y", int'(robot_y), mry);
            chk("pulse_overlap", int'(pkt_valid & pkt_err), 0);
            exp_rd = lookup(int'(rd_x), int'(rd_y));
            if (pkt_err) n_err++;
            if (pkt_valid) begin
                n_valid++;
                chk("valid_expected", int'(pend.size() > 0), 1);
                if (pend.size() > 0) apply(pend.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        tick(4);
        sclk  = 1'b1;
        tick(4);
        sclk  = 1'b0;
    endtask

    task automatic rd_cell(input int x, input int y, input int exp, input string name);
        rd_x = 3'(x);
        rd_y = 3'(y);
        tick(1);
        chk(name, int'(rd_state), exp);
    endtask

    // Returns on the sampling edge where the response pulse is seen.
    task automatic frame(input logic [8:0] bits, input int n, input string name);
        int lat = 0;
        int ok  = int'(n == 8 && int'(bits[7:5]) < GW && int'(bits[4:2]) < GH);
        int exp_lat = (n == 8) ? 5 : 4;
        cs_n = 1'b1;
        tick(5);
        cs_n = 1'b0;
        tick(4);
        for (int i = n - 1; i >= 0; i--) put_bit(bits[i]);
        tick(4);
        if (ok != 0) pend.push_back(bits[7:0]);
        cs_n = 1'b1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (pkt_valid || pkt_err) break;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_kind"}, int'(pkt_valid), ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) rd_cell(x, y, 0, "t1_cell");
        rd_cell(4, 0, 0, "t1_oor_x");
        rd_cell(0, 5, 0, "t1_oor_y");
        rd_cell(7, 7, 0, "t1_oor_xy");
        chk("t1_robot", int'({robot_x, robot_y}), 0);
        chk("t1_pulses", n_valid + n_err, 0);

        frame(9'b0_010_011_01, 8, "t2");
        tick(1);
        rd_cell(2, 3, 1, "t2_cell");
        rd_cell(0, 0, 0, "t2_other");
        rd_cell(3, 4, 0, "t2_other2");
        chk("t2_valid", n_valid, 1);

        frame(9'b0_001_001_10, 8, "t3_r11");
        frame(9'b0_001_010_10, 8, "t3_r12");
        tick(1);
        rd_cell(1, 1, 1, "t3_cell11");
        rd_cell(1, 2, 2, "t3_cell12");
        rd_cell(0, 0, 1, "t3_cell00");
        chk("t3_robot_x", int'(robot_x), 1);
        chk("t3_robot_y", int'(robot_y), 2);
        chk("t3_valid", n_valid, 3);

        frame(9'b0_001_010_10, 8, "t3_same");
        tick(1);
        rd_cell(1, 2, 2, "t3_same_cell");
        rd_cell(1, 1, 1, "t3_same_prev");
        chk("t3_same_valid", n_valid, 4);

        frame(9'b0_100_000_01, 8, "t4_range");
        frame(9'b0_0001_0101, 5, "t4_short");
        frame(9'b1_0010_0101, 9, "t4_long");
        tick(1);
        chk("t4_err", n_err, 3);
        chk("t4_valid", n_valid, 4);
        rd_cell(1, 1, 1, "t4_cell11");
        rd_cell(0, 0, 1, "t4_cell00");
        rd_cell(4, 0, 0, "t4_oor");

        cs_n = 1'b1;
        tick(5);
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        rd_cell(0, 0, 0, "t5_cell00");
        rd_cell(1, 2, 0, "t5_cell12");
        chk("t5_robot", int'({robot_x, robot_y}), 0);
        chk("t5_err", n_err, 3);

        rd_x = 3'd3;
        rd_y = 3'd4;
        frame(9'b0_011_100_11, 8, "t6");
        tick(1);
        chk("t6_collide", int'(rd_state), 0);
        tick(1);
        chk("t6_after", int'(rd_state), 3);
        chk("t6_valid", n_valid, 5);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
